// File: rtl/bcd_addsub_serial.sv
// ---------------------------------------------------------------------------
// bcd_addsub_serial
//   Digit-serial packed-BCD adder/subtractor. One BCD digit is processed per
//   clock, least-significant digit first, with valid/ready handshakes on the
//   operand side and on the result side.
//
// Parameters
//   DIGITS     number of BCD digits per operand (>= 1)
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operands present
//   in_ready   block can accept operands (high only while idle)
//   mode       0 = add (a+b+cin), 1 = subtract (a-b-cin)
//   a, b       packed BCD operands, digit 0 in [3:0]
//   cin        carry-in (add) or borrow-in (sub)
//   out_valid  result available (high only while done)
//   out_ready  consumer accepts result
//   result     packed BCD sum / difference
//   cout       final carry-out (add) or borrow-out (sub)
//   invalid    some operand digit was greater than 9 (sticky per operation)
//   neg        (SIGN_MAG_EN only) difference was negative, result holds
//              its magnitude
//
// Build option
//   SIGN_MAG_EN  when defined, a negative difference is converted to
//                sign/magnitude form by an extra serial pass (state FIX).
//                Otherwise it is left as its ten's complement with cout=1.
// ---------------------------------------------------------------------------
module bcd_addsub_serial #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  mode,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   result,
    output logic                  cout,
    output logic                  invalid
`ifdef SIGN_MAG_EN
    ,
    output logic                  neg
`endif
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
    localparam logic [IW-1:0] ONE_IDX  = IW'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
`ifdef SIGN_MAG_EN
    localparam logic [1:0] S_FIX  = 2'd3;
`endif

    // One BCD digit add: returns {carry, digit}.
    function automatic logic [4:0] bcd_add_digit(input logic [3:0] ad,
                                                 input logic [3:0] bd,
                                                 input logic       c);
        logic [4:0] s;
        s = {1'b0, ad} + {1'b0, bd} + {4'd0, c};
        if (s > 5'd9) begin
            bcd_add_digit = {1'b1, s[3:0] + 4'd6};
        end else begin
            bcd_add_digit = {1'b0, s[3:0]};
        end
    endfunction

    // One BCD digit subtract: returns {borrow, digit}. The 5-bit difference
    // is two's complement, so bit 4 set means it went negative.
    function automatic logic [4:0] bcd_sub_digit(input logic [3:0] ad,
                                                 input logic [3:0] bd,
                                                 input logic       c);
        logic [4:0] d;
        d = {1'b0, ad} - {1'b0, bd} - {4'd0, c};
        if (d[4]) begin
            bcd_sub_digit = {1'b1, d[3:0] + 4'd10};
        end else begin
            bcd_sub_digit = {1'b0, d[3:0]};
        end
    endfunction

    logic [1:0]            r_state;
    logic [IW-1:0]         r_idx;
    logic                  r_c;
    logic                  r_mode;
    logic [4*DIGITS-1:0]   r_a;
    logic [4*DIGITS-1:0]   r_b;
    logic [4*DIGITS-1:0]   r_result;
    logic                  r_cout;
    logic                  r_invalid;
`ifdef SIGN_MAG_EN
    logic                  r_neg;
`endif

    logic                  w_fix;
    logic [3:0]            w_ad;
    logic [3:0]            w_bd;
    logic [4:0]            w_step;
    logic                  w_bad_digit;

`ifdef SIGN_MAG_EN
    assign w_fix = (r_state == S_FIX);
`else
    assign w_fix = 1'b0;
`endif

    // Digit operand selection: the FIX pass computes 0 - result in place.
    always_comb begin
        w_ad        = 4'd0;
        w_bd        = 4'd0;
        w_step      = 5'd0;
        w_bad_digit = 1'b0;
        if (w_fix) begin
            w_ad = 4'd0;
            w_bd = r_result[r_idx*32'd4 +: 4];
        end else begin
            w_ad = r_a[r_idx*32'd4 +: 4];
            w_bd = r_b[r_idx*32'd4 +: 4];
        end
        if (w_fix || r_mode) begin
            w_step = bcd_sub_digit(w_ad, w_bd, r_c);
        end else begin
            w_step = bcd_add_digit(w_ad, w_bd, r_c);
        end
        if ((w_ad > 4'd9) || (w_bd > 4'd9)) begin
            w_bad_digit = 1'b1;
        end else begin
            w_bad_digit = 1'b0;
        end
    end

    // Control FSM and serial datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_c       <= 1'b0;
            r_mode    <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_result  <= '0;
            r_cout    <= 1'b0;
            r_invalid <= 1'b0;
`ifdef SIGN_MAG_EN
            r_neg     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a       <= a;
                        r_b       <= b;
                        r_mode    <= mode;
                        r_c       <= cin;
                        r_idx     <= '0;
                        r_invalid <= 1'b0;
                        r_result  <= '0;
`ifdef SIGN_MAG_EN
                        r_neg     <= 1'b0;
`endif
                        r_state   <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_result[r_idx*32'd4 +: 4] <= w_step[3:0];
                    r_c <= w_step[4];
                    if (w_bad_digit) begin
                        r_invalid <= 1'b1;
                    end
                    if (r_idx == LAST_IDX) begin
                        r_cout <= w_step[4];
                        r_idx  <= '0;
`ifdef SIGN_MAG_EN
                        // Negative difference: second pass takes the magnitude.
                        if (r_mode && w_step[4]) begin
                            r_c     <= 1'b0;
                            r_state <= S_FIX;
                        end else begin
                            r_state <= S_DONE;
                        end
`else
                        r_state <= S_DONE;
`endif
                    end else begin
                        r_idx <= r_idx + ONE_IDX;
                    end
                end
`ifdef SIGN_MAG_EN
                S_FIX: begin
                    r_result[r_idx*32'd4 +: 4] <= w_step[3:0];
                    r_c <= w_step[4];
                    if (r_idx == LAST_IDX) begin
                        r_idx   <= '0;
                        r_neg   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + ONE_IDX;
                    end
                end
`endif
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign cout      = r_cout;
    assign invalid   = r_invalid;
`ifdef SIGN_MAG_EN
    assign neg       = r_neg;
`endif

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// ---------------------------------------------------------------------------
// tb_bcd_addsub_serial
//   Directed self-checking bench for bcd_addsub_serial with DIGITS=4.
//   Inputs are driven 1 time unit after the rising edge, outputs are sampled
//   at that same point (away from the active edge).
// ---------------------------------------------------------------------------
module tb_bcd_addsub_serial;

    localparam int DIGITS = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic                 mode;
    logic [4*DIGITS-1:0]  a;
    logic [4*DIGITS-1:0]  b;
    logic                 cin;
    logic                 out_valid;
    logic                 out_ready;
    logic [4*DIGITS-1:0]  result;
    logic                 cout;
    logic                 invalid;
`ifdef SIGN_MAG_EN
    logic                 neg;
`endif

    int n_vec = 0;
    int n_err = 0;

    bcd_addsub_serial #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .invalid   (invalid)
`ifdef SIGN_MAG_EN
        ,
        .neg       (neg)
`endif
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one operation, measure latency, check outputs, optionally hold
    // off the consumer for 3 cycles, then accept the result.
    task automatic run_op(input string tag, input logic m, input logic [15:0] av,
                          input logic [15:0] bv, input logic ci,
                          input logic [15:0] er, input logic ec, input logic ei,
                          input logic en, input int elat, input bit hold);
        int lat;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        mode = m; a = av; b = bv; cin = ci; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // scramble operands: must be ignored after the accepting edge
        mode = ~m; a = ~av; b = ~bv; cin = ~ci;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(elat));
        check({tag, "_result"}, 32'(result), 32'(er));
        check({tag, "_cout"}, 32'(cout), 32'(ec));
        check({tag, "_invalid"}, 32'(invalid), 32'(ei));
`ifdef SIGN_MAG_EN
        check({tag, "_neg"}, 32'(neg), 32'(en));
`else
        if (en) begin
            check({tag, "_neg_unexpected"}, 32'd0, 32'd0);
        end
`endif
        if (hold) begin
            in_valid = 1'b1;
            mode = 1'b0; a = 16'h1111; b = 16'h2222; cin = 1'b1;
            for (int i = 0; i < 3; i++) begin
                @(posedge clk); #1;
                check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
                check({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
                check({tag, "_hold_result"}, 32'(result), 32'(er));
                check({tag, "_hold_cout"}, 32'(cout), 32'(ec));
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_released_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_released_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_kept_result"}, 32'(result), 32'(er));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; mode = 1'b0; a = '0; b = '0;
        cin = 1'b0; out_ready = 1'b0;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_invalid", 32'(invalid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_op("add_basic", 1'b0, 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b0, 4, 1'b0);
        run_op("add_wrap",  1'b0, 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4, 1'b0);
        run_op("sub_bin",   1'b1, 16'h1000, 16'h0000, 1'b1, 16'h0999, 1'b0, 1'b0, 1'b0, 4, 1'b0);
`ifdef SIGN_MAG_EN
        run_op("sub_neg",   1'b1, 16'h0042, 16'h0100, 1'b0, 16'h0058, 1'b1, 1'b0, 1'b1, 8, 1'b0);
`else
        run_op("sub_neg",   1'b1, 16'h0042, 16'h0100, 1'b0, 16'h9942, 1'b1, 1'b0, 1'b0, 4, 1'b0);
`endif
        run_op("add_bad",   1'b0, 16'h00A0, 16'h0001, 1'b0, 16'h0101, 1'b0, 1'b1, 1'b0, 4, 1'b0);
        run_op("add_cin",   1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 4, 1'b0);
        run_op("backpress", 1'b0, 16'h0500, 16'h0499, 1'b0, 16'h0999, 1'b0, 1'b0, 1'b0, 4, 1'b1);

        // Reset in the middle of CALC, after two digits.
        mode = 1'b0; a = 16'h1234; b = 16'h5678; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_cout", 32'(cout), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_op("after_rst", 1'b1, 16'h5000, 16'h1234, 1'b0, 16'h3766, 1'b0, 1'b0, 1'b0, 4, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
